// File: rtl/stn2tft_pkg.sv
// Shared geometry and types for the STN2TFT converter.
// The TFT scan-out block imports the same constants, so the frame RAM layout stays consistent.
package stn2tft_pkg;

  localparam int LINE_BYTES  = 32;
  localparam int FRAME_LINES = 192;
  localparam int ADDR_W      = 13;
  localparam int SYNC_STAGES = 2;
  localparam int RAM_DEPTH   = 6144;
  localparam int FIFO_W      = ADDR_W + 8;

  // Which half of the byte the next falling fpshift edge delivers.
  typedef enum logic {
    NIB_HI = 1'b0,
    NIB_LO = 1'b1
  } nib_phase_e;

endpackage

// File: rtl/stn_sync_edge.sv
// Multi-bit synchronizer with one history stage.
// Each bit produces its synced level plus single-cycle rise and fall strobes.
module stn_sync_edge #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] hist;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
      hist <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      hist <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = hist & ~level;

endmodule

// File: rtl/stn_capture.sv
// STN panel capture: samples the asynchronous panel bus, packs nibble pairs into bytes
// and queues frame-buffer writes through a two-entry FIFO toward the frame RAM.
module stn_capture #(
  parameter int LINE_BYTES  = stn2tft_pkg::LINE_BYTES,
  parameter int FRAME_LINES = stn2tft_pkg::FRAME_LINES,
  parameter int ADDR_W      = stn2tft_pkg::ADDR_W,
  parameter int SYNC_STAGES = stn2tft_pkg::SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              stn_fpframe,
  input  logic              stn_fpline,
  input  logic              stn_fpshift,
  input  logic [3:0]        stn_fpdat,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack,
  output logic              frame_start,
  output logic              locked,
  output logic              ovf
);

  import stn2tft_pkg::*;

  localparam int COL_W   = $clog2(LINE_BYTES + 1);
  localparam int ROW_W   = $clog2(FRAME_LINES + 1);
  localparam int ENTRY_W = ADDR_W + 8;

  localparam logic [COL_W-1:0]  COL_LIMIT = COL_W'(LINE_BYTES);
  localparam logic [ROW_W-1:0]  ROW_LIMIT = ROW_W'(FRAME_LINES);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);

  logic [6:0] sync_level;
  logic [6:0] sync_rise;
  logic [6:0] sync_fall;

  stn_sync_edge #(
    .WIDTH  (7),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_x (rst_x),
    .din   ({stn_fpframe, stn_fpline, stn_fpshift, stn_fpdat}),
    .level (sync_level),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  logic       line_rise;
  logic       shift_fall;
  logic       frame_level;
  logic [3:0] nib_data;
  logic       unused_edges;

  assign line_rise   = sync_rise[5];
  assign shift_fall  = sync_fall[4];
  assign frame_level = sync_level[6];
  assign nib_data    = sync_level[3:0];

  // Edge strobes and levels the capture logic has no use for are folded away here.
  assign unused_edges = ^{sync_rise[6], sync_rise[4:0], sync_fall[6:5],
                          sync_fall[3:0], sync_level[5:4]};

  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] line_base;
  logic [3:0]        byte_hi;
  nib_phase_e        nib_phase;

  logic              capture_shift;
  logic              push;
  logic [ENTRY_W-1:0] push_entry;
  logic              frame_clear;

  assign frame_clear = line_rise && frame_level;

  always_comb begin
    capture_shift = 1'b0;
    push          = 1'b0;
    if (shift_fall && !line_rise && locked && (row < ROW_LIMIT) && (col < COL_LIMIT)) begin
      capture_shift = 1'b1;
      push          = (nib_phase == NIB_LO);
    end
  end

  assign push_entry = {line_base + ADDR_W'(col), byte_hi, nib_data};

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      row         <= '0;
      col         <= '0;
      line_base   <= '0;
      byte_hi     <= '0;
      nib_phase   <= NIB_HI;
      locked      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (line_rise) begin
        col       <= '0;
        nib_phase <= NIB_HI;
        if (frame_level) begin
          row         <= '0;
          line_base   <= '0;
          frame_start <= 1'b1;
          locked      <= 1'b1;
        end else if (locked && (row < ROW_LIMIT)) begin
          row       <= row + 1'b1;
          line_base <= line_base + LINE_STEP;
        end
      end else if (capture_shift) begin
        if (nib_phase == NIB_HI) begin
          byte_hi   <= nib_data;
          nib_phase <= NIB_LO;
        end else begin
          nib_phase <= NIB_HI;
          col       <= col + 1'b1;
        end
      end
    end
  end

  logic [ENTRY_W-1:0] fifo_mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         fifo_count;
  logic               fifo_full;
  logic               pop;
  logic               push_ok;

  assign fifo_full = (fifo_count == 2'd2);
  assign wr_req    = (fifo_count != 2'd0);
  assign pop       = wr_req && wr_ack;
  // When full, a same-cycle pop frees exactly the slot the write pointer targets.
  assign push_ok   = push && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign {wr_addr, wr_data} = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      ovf <= 1'b0;
    end else if (frame_clear) begin
      ovf <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stn_capture.sv
// Directed bench for stn_capture: frame/line capture, overflow, line and frame limits, async reset.
module tb_stn_capture;

  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic        fpframe = 1'b0;
  logic        fpline = 1'b0;
  logic        fpshift = 1'b0;
  logic [3:0]  fpdat = 4'h0;
  logic        wr_ack = 1'b0;
  logic        wr_req;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        frame_start;
  logic        locked;
  logic        ovf;

  int tests_run = 0;
  int tests_failed = 0;
  int fs_count = 0;
  logic [12:0] addr_log [$];
  logic [7:0]  data_log [$];

  always #5 clk = ~clk;

  stn_capture dut (
    .clk         (clk),
    .rst_x       (rst_x),
    .stn_fpframe (fpframe),
    .stn_fpline  (fpline),
    .stn_fpshift (fpshift),
    .stn_fpdat   (fpdat),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .frame_start (frame_start),
    .locked      (locked),
    .ovf         (ovf)
  );

  // Inputs change just after the rising edge, so the falling edge sees settled handshakes.
  always @(negedge clk) begin
    if (rst_x) begin
      if (wr_req && wr_ack) begin
        addr_log.push_back(wr_addr);
        data_log.push_back(wr_data);
      end
      if (frame_start) fs_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] nib);
    fpdat   = nib;
    fpshift = 1'b1;
    tick(4);
    fpshift = 1'b0;
    tick(4);
  endtask

  task automatic send_line(input logic frame);
    fpframe = frame;
    fpline  = 1'b1;
    tick(4);
    fpline  = 1'b0;
    fpframe = 1'b0;
    tick(4);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int fs_base;
    int bad;
    int max_addr;
    logic [3:0] hi;
    logic [3:0] lo;

    wr_ack = 1'b1;
    tick(3);
    checkOutput("reset_wr_req", wr_req, 0);
    checkOutput("reset_wr_addr", wr_addr, 0);
    checkOutput("reset_wr_data", wr_data, 0);
    checkOutput("reset_frame_start", frame_start, 0);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_ovf", ovf, 0);
    rst_x = 1'b1;
    tick(3);

    base = addr_log.size();
    send_line(1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(4'h9);
    tick(4);
    checkOutput("preframe_writes", addr_log.size() - base, 0);
    checkOutput("preframe_locked", locked, 0);
    checkOutput("preframe_wr_req", wr_req, 0);

    base = addr_log.size();
    fs_base = fs_count;
    send_line(1'b1);
    for (int i = 0; i < 64; i++) applyStimulus((i % 2 == 0) ? 4'hA : 4'h5);
    tick(4);
    checkOutput("frame0_write_count", addr_log.size() - base, 32);
    bad = 0;
    if (addr_log.size() - base == 32) begin
      for (int k = 0; k < 32; k++) begin
        if (addr_log[base+k] !== 13'(k) || data_log[base+k] !== 8'hA5) bad++;
      end
    end
    checkOutput("frame0_bad_entries", bad, 0);
    checkOutput("frame0_start_pulses", fs_count - fs_base, 1);
    checkOutput("frame0_locked", locked, 1);

    base = addr_log.size();
    send_line(1'b0);
    applyStimulus(4'h1);
    applyStimulus(4'h2);
    applyStimulus(4'h3);
    applyStimulus(4'h4);
    tick(4);
    checkOutput("line1_write_count", addr_log.size() - base, 2);
    if (addr_log.size() - base == 2) begin
      checkOutput("line1_addr0", addr_log[base], 32);
      checkOutput("line1_data0", data_log[base], 8'h12);
      checkOutput("line1_addr1", addr_log[base+1], 33);
      checkOutput("line1_data1", data_log[base+1], 8'h34);
    end

    base = addr_log.size();
    wr_ack = 1'b0;
    send_line(1'b0);
    for (int i = 1; i <= 6; i++) applyStimulus(4'(i));
    tick(4);
    checkOutput("ovf_stalled_writes", addr_log.size() - base, 0);
    checkOutput("ovf_wr_req_held", wr_req, 1);
    checkOutput("ovf_flag_set", ovf, 1);
    wr_ack = 1'b1;
    tick(6);
    checkOutput("ovf_drain_count", addr_log.size() - base, 2);
    if (addr_log.size() - base == 2) begin
      checkOutput("ovf_drain_addr0", addr_log[base], 64);
      checkOutput("ovf_drain_data0", data_log[base], 8'h12);
      checkOutput("ovf_drain_addr1", addr_log[base+1], 65);
      checkOutput("ovf_drain_data1", data_log[base+1], 8'h34);
    end
    checkOutput("ovf_sticky", ovf, 1);
    fs_base = fs_count;
    send_line(1'b1);
    checkOutput("ovf_cleared_by_frame", ovf, 0);
    checkOutput("frame1_start_pulses", fs_count - fs_base, 1);

    base = addr_log.size();
    for (int i = 0; i < 70; i++) applyStimulus(4'(i % 16));
    tick(4);
    checkOutput("longline_write_count", addr_log.size() - base, 32);
    bad = 0;
    if (addr_log.size() - base == 32) begin
      for (int k = 0; k < 32; k++) begin
        hi = 4'((2 * k) % 16);
        lo = 4'((2 * k + 1) % 16);
        if (addr_log[base+k] !== 13'(k) || data_log[base+k] !== {hi, lo}) bad++;
      end
    end
    checkOutput("longline_bad_entries", bad, 0);

    base = addr_log.size();
    for (int r = 0; r < 200; r++) begin
      send_line(1'b0);
      applyStimulus(4'h7);
      applyStimulus(4'hE);
    end
    tick(4);
    checkOutput("manylines_write_count", addr_log.size() - base, 191);
    bad = 0;
    max_addr = 0;
    for (int k = base; k < addr_log.size(); k++) begin
      if (int'(addr_log[k]) > max_addr) max_addr = int'(addr_log[k]);
      if (addr_log[k] !== 13'((k - base + 1) * 32) || data_log[k] !== 8'h7E) bad++;
    end
    checkOutput("manylines_bad_entries", bad, 0);
    checkOutput("manylines_max_addr", max_addr, 6112);

    wr_ack = 1'b0;
    send_line(1'b1);
    applyStimulus(4'h8);
    applyStimulus(4'h1);
    applyStimulus(4'h6);
    checkOutput("midline_wr_req_before_reset", wr_req, 1);
    #2;
    rst_x = 1'b0;
    #1;
    checkOutput("midline_wr_req_async", wr_req, 0);
    checkOutput("midline_locked_cleared", locked, 0);
    tick(2);
    rst_x = 1'b1;
    wr_ack = 1'b1;
    tick(2);
    base = addr_log.size();
    send_line(1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(4'hB);
    tick(4);
    checkOutput("postreset_no_writes", addr_log.size() - base, 0);
    checkOutput("postreset_locked", locked, 0);
    send_line(1'b1);
    applyStimulus(4'hC);
    applyStimulus(4'h3);
    tick(4);
    checkOutput("postreset_write_count", addr_log.size() - base, 1);
    if (addr_log.size() - base == 1) begin
      checkOutput("postreset_addr", addr_log[base], 0);
      checkOutput("postreset_data", data_log[base], 8'hC3);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
